// File: rtl/pcileech_tlp_framer_pkg.sv
// Shared constants, FSM encoding and the 64-bit FT601 word layout for the TLP framer.
// The packed struct order defines the output field offsets, from bit 63 down to bit 0.
package pcileech_pkg;

  localparam logic [7:0] FT_MAGIC     = 8'h77;
  localparam logic [1:0] FT_TYPE_CFG  = 2'b00;
  localparam logic [1:0] FT_TYPE_PCIE = 2'b11;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_DROP  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] dw;     // [63:32]
    logic [7:0]  seq;    // [31:24]
    logic [7:0]  idx;    // [23:16]
    logic [3:0]  rsvd;   // [15:12]
    logic        bm;     // [11]
    logic        last;   // [10]
    logic [1:0]  typ;    // [9:8]
    logic [7:0]  magic;  // [7:0]
  } ft_word_t;

endpackage

// File: rtl/pcileech_tlp_framer_if.sv
// Generic valid/ready word stream; master drives data/valid, slave drives ready.
interface pcileech_tlp_framer_if #(parameter int W = 34);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pcileech_tlp_buf.sv
// One-TLP dword store: synchronous write, asynchronous read (LUT RAM).
// No reset; contents are only read after being written for the current TLP.
module pcileech_tlp_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pcileech_tlp_framer.sv
// Store-and-forward TLP framer: buffers one TLP, then emits one 64-bit FT601 word per dword.
// Output valid rises the cycle after the tlast handshake; input is stalled for the whole drain.
module pcileech_tlp_framer
  import pcileech_pkg::*;
#(
  parameter int MAX_DW    = 32,
  parameter bit BM_FILTER = 1'b0
) (
  input  logic                 user_clk,
  input  logic                 user_reset_n,
  pcileech_tlp_framer_if.slave  tlp_in,
  pcileech_tlp_framer_if.master tlp_out,
  output logic [15:0]          pkt_count,
  output logic [15:0]          drop_count
);

  localparam int IW = (MAX_DW > 1) ? $clog2(MAX_DW) : 1;
  localparam int LW = $clog2(MAX_DW + 1);

  state_t        state, state_n;
  logic [IW-1:0] wr_idx, wr_idx_n;
  logic [IW-1:0] rd_idx, rd_idx_n;
  logic [LW-1:0] len, len_n;
  logic          bm_q, bm_n;
  logic [7:0]    seq, seq_n;
  logic [15:0]   pkt_cnt, pkt_cnt_n;
  logic [15:0]   drop_cnt, drop_cnt_n;

  logic          in_ready, in_fire, in_last, in_bm;
  logic          out_valid, out_fire, rd_last, buf_we;
  logic [31:0]   rd_dat;
  logic [15:0]   drop_sat;
  ft_word_t      word;

  pcileech_tlp_buf #(.DEPTH(MAX_DW), .AW(IW)) u_buf (
    .clk   (user_clk),
    .we    (buf_we),
    .waddr (wr_idx),
    .wdata (tlp_in.data[31:0]),
    .raddr (rd_idx),
    .rdata (rd_dat)
  );

  // Ready is gated by reset directly so nothing is accepted while held in reset.
  assign in_ready  = user_reset_n && (state != S_DRAIN);
  assign out_valid = (state == S_DRAIN);
  assign in_fire   = tlp_in.valid && in_ready;
  assign out_fire  = out_valid && tlp_out.ready;
  assign in_last   = tlp_in.data[32];
  assign in_bm     = tlp_in.data[33];
  assign rd_last   = ((LW'(rd_idx) + LW'(1)) == len);
  assign drop_sat  = (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;

  always_comb begin
    state_n    = state;
    wr_idx_n   = wr_idx;
    rd_idx_n   = rd_idx;
    len_n      = len;
    bm_n       = bm_q;
    seq_n      = seq;
    pkt_cnt_n  = pkt_cnt;
    drop_cnt_n = drop_cnt;
    buf_we     = 1'b0;
    case (state)
      S_FILL: begin
        if (in_fire) begin
          buf_we = 1'b1;
          if (in_last) begin
            if (BM_FILTER && !in_bm) begin
              drop_cnt_n = drop_sat;
              wr_idx_n   = '0;
            end else begin
              len_n   = LW'(wr_idx) + LW'(1);
              bm_n    = in_bm;
              state_n = S_DRAIN;
            end
          end else if (wr_idx == IW'(MAX_DW - 1)) begin
            state_n = S_DROP;
          end else begin
            wr_idx_n = wr_idx + IW'(1);
          end
        end
      end
      S_DROP: begin
        if (in_fire && in_last) begin
          drop_cnt_n = drop_sat;
          wr_idx_n   = '0;
          state_n    = S_FILL;
        end
      end
      S_DRAIN: begin
        if (out_fire) begin
          if (rd_last) begin
            pkt_cnt_n = pkt_cnt + 16'd1;
            seq_n     = seq + 8'd1;
            rd_idx_n  = '0;
            wr_idx_n  = '0;
            state_n   = S_FILL;
          end else begin
            rd_idx_n = rd_idx + IW'(1);
          end
        end
      end
      default: state_n = S_FILL;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state    <= S_FILL;
      wr_idx   <= '0;
      rd_idx   <= '0;
      len      <= '0;
      bm_q     <= 1'b0;
      seq      <= 8'd0;
      pkt_cnt  <= 16'd0;
      drop_cnt <= 16'd0;
    end else begin
      state    <= state_n;
      wr_idx   <= wr_idx_n;
      rd_idx   <= rd_idx_n;
      len      <= len_n;
      bm_q     <= bm_n;
      seq      <= seq_n;
      pkt_cnt  <= pkt_cnt_n;
      drop_cnt <= drop_cnt_n;
    end
  end

  always_comb begin
    word       = '0;
    word.dw    = rd_dat;
    word.seq   = seq;
    word.idx   = 8'(rd_idx);
    word.rsvd  = 4'd0;
    word.bm    = bm_q;
    word.last  = rd_last;
    word.typ   = FT_TYPE_PCIE;
    word.magic = FT_MAGIC;
  end

  assign tlp_in.ready  = in_ready;
  assign tlp_out.valid = out_valid;
  assign tlp_out.data  = word;
  assign pkt_count     = pkt_cnt;
  assign drop_count    = drop_cnt;

endmodule

// File: tb/tb_pcileech_tlp_framer.sv
// Directed bench for pcileech_tlp_framer: dut0 unfiltered, dut1 with the bus-master filter.
module tb_pcileech_tlp_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic [33:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  logic [31:0] tx [64];
  logic [63:0] rx [$];

  pcileech_tlp_framer_if #(.W(34)) i0_in ();
  pcileech_tlp_framer_if #(.W(64)) i0_out ();
  pcileech_tlp_framer_if #(.W(34)) i1_in ();
  pcileech_tlp_framer_if #(.W(64)) i1_out ();

  logic [15:0] pkt0, drop0, pkt1, drop1;

  assign i0_in.data   = in_data;
  assign i1_in.data   = in_data;
  assign i0_in.valid  = in_valid & ~sel;
  assign i1_in.valid  = in_valid & sel;
  assign i0_out.ready = out_ready;
  assign i1_out.ready = out_ready;

  pcileech_tlp_framer #(.MAX_DW(32), .BM_FILTER(1'b0)) dut0 (
    .user_clk(clk), .user_reset_n(rst_n), .tlp_in(i0_in), .tlp_out(i0_out),
    .pkt_count(pkt0), .drop_count(drop0));

  pcileech_tlp_framer #(.MAX_DW(32), .BM_FILTER(1'b1)) dut1 (
    .user_clk(clk), .user_reset_n(rst_n), .tlp_in(i1_in), .tlp_out(i1_out),
    .pkt_count(pkt1), .drop_count(drop1));

  wire        o_in_ready = sel ? i1_in.ready : i0_in.ready;
  wire        o_valid    = sel ? i1_out.valid : i0_out.valid;
  wire [63:0] o_data     = sel ? i1_out.data : i0_out.data;
  wire [15:0] o_pkt      = sel ? pkt1 : pkt0;
  wire [15:0] o_drop     = sel ? drop1 : drop0;

  always #5 clk = ~clk;

  function automatic logic [63:0] ft(input logic [31:0] dw, input logic [7:0] idx,
                                     input logic [7:0] seq, input logic last, input logic bm);
    return {dw, seq, idx, 4'b0000, bm, last, 2'b11, 8'h77};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_words(input int n, input logic bm, input logic with_last);
    for (int i = 0; i < n; i++) begin
      int wait_cyc;
      @(negedge clk);
      in_data  = {bm, (with_last && i == n - 1), tx[i]};
      in_valid = 1'b1;
      wait_cyc = 0;
      while (!o_in_ready && wait_cyc < 100) begin
        @(negedge clk);
        wait_cyc++;
      end
      checks++;
      if (!o_in_ready) begin
        failures++;
        $display("FAIL send_ready word %0d: in_ready=%b required 1", i, o_in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Collects n output words; checks first-cycle latency, stall stability and input back-pressure.
  task automatic drain(input int n, input bit rnd);
    bit          stalled = 0;
    logic [63:0] held = '0;
    bit          saw_valid = 0;
    rx.delete();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c == 0 && n > 0) begin
        checks++;
        if (o_valid !== 1'b1) begin
          failures++;
          $display("FAIL latency: out_valid=%b required 1 one cycle after tlast", o_valid);
        end
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        checks++;
        if (o_valid !== 1'b1 || o_data !== held) begin
          failures++;
          $display("FAIL stall_hold: valid=%b data=%h required 1 %h", o_valid, o_data, held);
        end
      end
      if (o_valid) begin
        saw_valid = 1;
        checks++;
        if (o_in_ready !== 1'b0) begin
          failures++;
          $display("FAIL drain_in_ready: in_ready=%b required 0", o_in_ready);
        end
      end
      stalled = o_valid && !out_ready;
      held    = o_data;
      if (o_valid && out_ready) rx.push_back(o_data);
      if (n > 0 && rx.size() == n) begin
        @(posedge clk);
        break;
      end
      if (n == 0 && c >= 40) break;
    end
    out_ready = 1'b1;
    if (n > 0) begin
      @(negedge clk);
      checks++;
      if (o_in_ready !== 1'b1 || o_valid !== 1'b0) begin
        failures++;
        $display("FAIL refill: in_ready=%b valid=%b required 1 0", o_in_ready, o_valid);
      end
    end else begin
      checks++;
      if (saw_valid) begin
        failures++;
        $display("FAIL no_output: out_valid seen=1 required 0");
      end
    end
  endtask

  task automatic check_rx(input string name, input int n, input logic [7:0] seq, input logic bm);
    checks++;
    if (rx.size() != n) begin
      failures++;
      $display("FAIL %s count: got %0d words required %0d", name, rx.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        logic [63:0] exp;
        exp = ft(tx[i], 8'(i), seq, (i == n - 1), bm);
        checks++;
        if (rx[i] !== exp) begin
          failures++;
          $display("FAIL %s word %0d: got %h required %h", name, i, rx[i], exp);
        end
      end
    end
  endtask

  task automatic check_cnt(input string name, input logic [15:0] pkt, input logic [15:0] drop);
    checks++;
    if (o_pkt !== pkt || o_drop !== drop) begin
      failures++;
      $display("FAIL %s counters: pkt=%h drop=%h required %h %h", name, o_pkt, o_drop, pkt, drop);
    end
  endtask

  task automatic fill_tx(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) tx[i] = base + 32'(i) * 32'h01010101;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checks++;
    if (o_in_ready !== 1'b0 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: in_ready=%b valid=%b required 0 0", o_in_ready, o_valid);
    end
    check_cnt("reset", 16'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (o_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b required 1", o_in_ready);
    end
  endtask

  task automatic test_basic();
    sel = 1'b0;
    apply_reset();
    tx[0] = 32'h11111111; tx[1] = 32'h22222222; tx[2] = 32'h33333333;
    send_words(3, 1'b1, 1'b1);
    drain(3, 0);
    check_rx("basic", 3, 8'd0, 1'b1);
    check_cnt("basic", 16'd1, 16'd0);
  endtask

  task automatic test_oversize();
    sel = 1'b0;
    apply_reset();
    fill_tx(33, 32'h50000000);
    send_words(33, 1'b1, 1'b1);
    drain(0, 0);
    check_cnt("oversize", 16'd0, 16'd1);
    tx[0] = 32'hAABBCCDD;
    send_words(1, 1'b1, 1'b1);
    drain(1, 0);
    check_rx("single", 1, 8'd0, 1'b1);
    fill_tx(32, 32'h60000000);
    send_words(32, 1'b0, 1'b1);
    drain(32, 0);
    check_rx("exact_max", 32, 8'd1, 1'b0);
    check_cnt("exact_max", 16'd2, 16'd1);
  endtask

  task automatic test_bm_filter();
    sel = 1'b1;
    apply_reset();
    tx[0] = 32'hCAFE0000; tx[1] = 32'hCAFE0001;
    send_words(2, 1'b0, 1'b1);
    drain(0, 0);
    check_cnt("bm_drop", 16'd0, 16'd1);
    send_words(2, 1'b1, 1'b1);
    drain(2, 0);
    check_rx("bm_pass", 2, 8'd0, 1'b1);
    check_cnt("bm_pass", 16'd1, 16'd1);
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    apply_reset();
    fill_tx(4, 32'hA0000000);
    send_words(4, 1'b1, 1'b1);
    drain(4, 1);
    check_rx("stall_tlp0", 4, 8'd0, 1'b1);
    fill_tx(3, 32'hB0000000);
    send_words(3, 1'b0, 1'b1);
    drain(3, 1);
    check_rx("stall_tlp1", 3, 8'd1, 1'b0);
    check_cnt("stall", 16'd2, 16'd0);
  endtask

  task automatic test_reset_mid_packet();
    sel = 1'b0;
    fill_tx(8, 32'hD0000000);
    send_words(5, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b in_ready=%b required 0 0", o_valid, o_in_ready);
    end
    check_cnt("mid_reset", 16'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_words(8, 1'b1, 1'b1);
    drain(8, 0);
    check_rx("after_reset", 8, 8'd0, 1'b1);
    check_cnt("after_reset", 16'd1, 16'd0);
  endtask

  task automatic test_saturation();
    sel = 1'b0;
    @(negedge clk);
    force dut0.drop_cnt = 16'hFFFD;
    force dut0.pkt_cnt  = 16'hFFFF;
    #1;
    release dut0.drop_cnt;
    release dut0.pkt_cnt;
    fill_tx(33, 32'hE0000000);
    send_words(33, 1'b1, 1'b1);
    drain(0, 0);
    check_cnt("sat_fffe", 16'hFFFF, 16'hFFFE);
    send_words(33, 1'b1, 1'b1);
    drain(0, 0);
    check_cnt("sat_ffff", 16'hFFFF, 16'hFFFF);
    send_words(33, 1'b1, 1'b1);
    drain(0, 0);
    check_cnt("sat_hold", 16'hFFFF, 16'hFFFF);
    tx[0] = 32'h0BADF00D;
    send_words(1, 1'b1, 1'b1);
    drain(1, 0);
    check_cnt("pkt_wrap", 16'h0000, 16'hFFFF);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_oversize();
    test_bm_filter();
    test_back_to_back();
    test_reset_mid_packet();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
